raster_scan_gen: RTL and testbench

Raster-scan pixel sequencer that drives the vertical edge classifier and vertical filter. It walks the image top-left to bottom-right and issues BRAM read addresses with valid, first-column, last-column and last-row strobes. After the last row it issues one flush row with valid low, so downstream logic can emit bottom-edge results. It honours the downstream stall signal, and its strobes are guaranteed to pulse once per accepted beat.

---
 rtl/raster_scan_gen.sv | 180 ++++++++++++++++++
 tb/tb_raster_scan_gen.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/raster_scan_gen.sv
// Raster-scan BRAM read sequencer: walks a latched width x height frame, then one flush row.
// Optional macro RASTER_ROW_GAP_EN forces one bubble cycle after every last-column beat.
module raster_scan_gen #(
  parameter int XB = 10,
  parameter int YB = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [XB-1:0]    i_width,
  input  logic [YB-1:0]    i_height,
  input  logic             i_stall,
  output logic             o_valid_data,
  output logic             o_col1,
  output logic             o_maxcol,
  output logic             o_maxrow,
  output logic [XB+YB-1:0] o_addr,
  output logic             o_busy,
  output logic             o_done,
  output logic [1:0]       dbg_state
);
  localparam int AW = XB + YB;

`ifdef RASTER_ROW_GAP_EN
  localparam logic GAP_EN = 1'b1;
`else
  localparam logic GAP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [XB-1:0]   col_q, col_d, maxcol_q, maxcol_d;
  logic [YB-1:0]   row_q, row_d, maxrow_q, maxrow_d;
  logic [AW-1:0]   lin_q, lin_d;
  logic            gap_q, gap_d;
  logic            valid_q, valid_d, col1_q, col1_d, mcol_q, mcol_d, mrow_q, mrow_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            busy_q, busy_d, done_q, done_d;

  // Flow control: a beat appears in cycle t+1 only when i_stall is low in
  // cycle t (and no forced gap is pending); otherwise t+1 is a bubble and
  // every counter holds. There is no other handshake on this block.
  logic            start_ok, scanning, issue;
  logic [XB-1:0]   cur_col, cur_maxcol;
  logic [YB-1:0]   cur_row, cur_maxrow;
  logic [AW-1:0]   cur_lin;

  always_comb begin
    start_ok   = (state_q == S_IDLE) && i_start && (i_width != '0) && (i_height >= YB'(3));
    // The start edge already issues pixel (0,0), so it sees the freshly latched sizes.
    cur_maxcol = start_ok ? (i_width - XB'(1)) : maxcol_q;
    cur_maxrow = start_ok ? (i_height - YB'(1)) : maxrow_q;
    cur_col    = start_ok ? '0 : col_q;
    cur_row    = start_ok ? '0 : row_q;
    cur_lin    = start_ok ? '0 : lin_q;
    scanning   = start_ok || (state_q == S_SCAN);
    issue      = !i_stall && !gap_q;
  end

  always_comb begin
    state_d  = state_q;
    col_d    = cur_col;
    row_d    = cur_row;
    lin_d    = cur_lin;
    maxcol_d = cur_maxcol;
    maxrow_d = cur_maxrow;
    gap_d    = gap_q;
    valid_d  = 1'b0;
    col1_d   = 1'b0;
    mcol_d   = 1'b0;
    mrow_d   = 1'b0;
    addr_d   = addr_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    if (scanning) begin
      state_d = S_SCAN;
      busy_d  = 1'b1;
      if (issue) begin
        valid_d = 1'b1;
        col1_d  = (cur_col == '0);
        mcol_d  = (cur_col == cur_maxcol);
        mrow_d  = (cur_row == cur_maxrow);
        addr_d  = cur_lin;
        lin_d   = cur_lin + AW'(1);
        if (cur_col == cur_maxcol) begin
          col_d = '0;
          gap_d = GAP_EN;
          if (cur_row == cur_maxrow) state_d = S_FLUSH;
          else                       row_d   = cur_row + YB'(1);
        end else begin
          col_d = cur_col + XB'(1);
        end
      end else begin
        gap_d = 1'b0;
      end
    end else begin
      case (state_q)
        S_FLUSH: begin
          if (issue) begin
            col1_d = (col_q == '0);
            mcol_d = (col_q == maxcol_q);
            if (col_q == maxcol_q) begin
              col_d   = '0;
              gap_d   = GAP_EN;
              state_d = S_DONE;
            end else begin
              col_d = col_q + XB'(1);
            end
          end else begin
            gap_d = 1'b0;
          end
        end
        S_DONE: begin
          // A pending gap after the last flush beat delays the done pulse.
          if (gap_q) begin
            gap_d = 1'b0;
          end else begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      col_q    <= '0;
      row_q    <= '0;
      lin_q    <= '0;
      maxcol_q <= '0;
      maxrow_q <= '0;
      gap_q    <= 1'b0;
      valid_q  <= 1'b0;
      col1_q   <= 1'b0;
      mcol_q   <= 1'b0;
      mrow_q   <= 1'b0;
      addr_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      row_q    <= row_d;
      lin_q    <= lin_d;
      maxcol_q <= maxcol_d;
      maxrow_q <= maxrow_d;
      gap_q    <= gap_d;
      valid_q  <= valid_d;
      col1_q   <= col1_d;
      mcol_q   <= mcol_d;
      mrow_q   <= mrow_d;
      addr_q   <= addr_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign o_valid_data = valid_q;
  assign o_col1       = col1_q;
  assign o_maxcol     = mcol_q;
  assign o_maxrow     = mrow_q;
  assign o_addr       = addr_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_raster_scan_gen.sv
// Bench for raster_scan_gen: a beat-list reference model checked every cycle,
// directed frames with hand-computed cycle expectations, then random traffic.
module tb_raster_scan_gen;
  localparam int XB = 10;
  localparam int YB = 10;
  localparam int AW = XB + YB;
  localparam int BW = AW + 4;
  localparam int OW = AW + 6;
`ifdef RASTER_ROW_GAP_EN
  localparam bit GAP = 1'b1;
`else
  localparam bit GAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, i_start, i_stall;
  logic [XB-1:0] i_width;
  logic [YB-1:0] i_height;
  logic o_valid_data, o_col1, o_maxcol, o_maxrow, o_busy, o_done;
  logic [AW-1:0] o_addr;
  logic [1:0] dbg_state;

  raster_scan_gen #(.XB(XB), .YB(YB)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_width(i_width), .i_height(i_height),
    .i_stall(i_stall), .o_valid_data(o_valid_data), .o_col1(o_col1), .o_maxcol(o_maxcol),
    .o_maxrow(o_maxrow), .o_addr(o_addr), .o_busy(o_busy), .o_done(o_done),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // reference model: the frame is a list of beats {valid,col1,maxcol,maxrow,addr}
  logic [BW-1:0] exp_q[$];
  bit m_busy = 0, m_donep = 0, m_gap = 0;
  logic e_busy = 0, e_done = 0, e_valid = 0, e_col1 = 0, e_maxcol = 0, e_maxrow = 0;
  logic [AW-1:0] e_addr = '0;

  task automatic build_frame(input int w, input int h);
    exp_q.delete();
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++)
        exp_q.push_back({1'b1, c == 0, c == w - 1, r == h - 1, AW'(r * w + c)});
    for (int c = 0; c < w; c++)
      exp_q.push_back({1'b0, c == 0, c == w - 1, 1'b0, AW'(w * h - 1)});
  endtask

  task automatic model_step();
    logic [BW-1:0] b;
    e_done = 0; e_valid = 0; e_col1 = 0; e_maxcol = 0; e_maxrow = 0;
    if (rst) begin
      e_busy = 0; e_addr = '0; exp_q.delete();
      m_busy = 0; m_donep = 0; m_gap = 0;
    end else if (m_donep) begin
      if (m_gap) m_gap = 0;
      else begin
        e_done = 1; e_busy = 0; m_donep = 0; m_busy = 0;
      end
    end else begin
      if (!m_busy && i_start && int'(i_width) >= 1 && int'(i_height) >= 3) begin
        build_frame(int'(i_width), int'(i_height));
        m_busy = 1; e_busy = 1;
      end
      if (m_busy) begin
        if (m_gap) m_gap = 0;
        else if (!i_stall) begin
          b = exp_q.pop_front();
          {e_valid, e_col1, e_maxcol, e_maxrow, e_addr} = b;
          if (e_maxcol && GAP) m_gap = 1;
          if (exp_q.size() == 0) m_donep = 1;
        end
      end
    end
  endtask

  // scoreboard compare, every cycle on the falling edge
  initial begin
    logic [OW-1:0] got, exp;
    bit primed;
    primed = 0;
    forever begin
      @(negedge clk);
      if (primed) begin
        got = {o_busy, o_done, o_valid_data, o_col1, o_maxcol, o_maxrow, o_addr};
        exp = {e_busy, e_done, e_valid, e_col1, e_maxcol, e_maxrow, e_addr};
        checks++;
        if (got !== exp) begin
          failures++;
          $display("FAIL cycle_cmp t=%0t got busy=%b done=%b v=%b c1=%b mc=%b mr=%b addr=%0d exp busy=%b done=%b v=%b c1=%b mc=%b mr=%b addr=%0d",
                   $time, o_busy, o_done, o_valid_data, o_col1, o_maxcol, o_maxrow, o_addr,
                   e_busy, e_done, e_valid, e_col1, e_maxcol, e_maxrow, e_addr);
        end
      end
      model_step();
      primed = 1;
    end
  end

  // trace capture for literal expectations
  logic tr_v[64], tr_c1[64], tr_mc[64], tr_mr[64], tr_busy[64], tr_done[64];
  logic [AW-1:0] tr_addr[64];

  task automatic chk(input string name, input logic [AW-1:0] got, input logic [AW-1:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, want);
    end
  endtask

  // driver: start on cycle 0, stall on cycles sa/sb, reset on cycle ra
  task automatic run_trace(input int w, input int h, input int sa, input int sb, input int ra, input int n);
    i_width = XB'(w); i_height = YB'(h); i_start = 1;
    i_stall = (sa == 0 || sb == 0); rst = (ra == 0);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      tr_v[k] = o_valid_data; tr_c1[k] = o_col1; tr_mc[k] = o_maxcol; tr_mr[k] = o_maxrow;
      tr_busy[k] = o_busy; tr_done[k] = o_done; tr_addr[k] = o_addr;
      @(posedge clk); #1;
      i_start = 0;
      i_stall = (k + 1 == sa || k + 1 == sb);
      rst = (k + 1 == ra);
    end
    rst = 0; i_stall = 0;
  endtask

  initial begin
    rst = 1; i_start = 0; i_stall = 0; i_width = 4; i_height = 3;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(posedge clk); #1;

    // 4x3, no stall
    run_trace(4, 3, -1, -1, -1, 26);
    chk("busy_c1", AW'(tr_busy[1]), 1);
    chk("addr_c1", tr_addr[1], 0);
    chk("col1_c1", AW'(tr_c1[1]), 1);
    chk("mrow_c4", AW'(tr_mr[4]), 0);
`ifdef RASTER_ROW_GAP_EN
    chk("gap_c5", AW'(tr_v[5]), 0);
    chk("addr_c6", tr_addr[6], 4);
    chk("flush_c16", AW'({tr_v[16], tr_c1[16]}), 1);
    chk("flush_mc19", AW'(tr_mc[19]), 1);
    chk("done_c20", AW'(tr_done[20]), 0);
    chk("done_c21", AW'(tr_done[21]), 1);
    chk("busy_c21", AW'(tr_busy[21]), 0);
`else
    chk("addr_c12", tr_addr[12], 11);
    chk("mrow_c9", AW'(tr_mr[9]), 1);
    chk("mc_c8", AW'(tr_mc[8]), 1);
    chk("flush_c13", AW'({tr_v[13], tr_c1[13]}), 1);
    chk("flush_addr16", tr_addr[16], 11);
    chk("flush_mc16", AW'(tr_mc[16]), 1);
    chk("done_c16", AW'(tr_done[16]), 0);
    chk("done_c17", AW'(tr_done[17]), 1);
    chk("busy_c17", AW'(tr_busy[17]), 0);
`endif

    // 4x3, stall on cycles 2 and 3
    run_trace(4, 3, 2, 3, -1, 28);
    chk("stall_v3", AW'(tr_v[3]), 0);
    chk("stall_addr3", tr_addr[3], 1);
    chk("stall_addr4", tr_addr[4], 1);
    chk("stall_addr5", tr_addr[5], 2);
    chk("stall_v5", AW'(tr_v[5]), 1);
    chk("stall_done", AW'(tr_done[GAP ? 23 : 19]), 1);

    // illegal sizes then a legal start
    run_trace(4, 2, -1, -1, -1, 4);
    for (int k = 1; k < 4; k++) chk("illegal_h_busy", AW'(tr_busy[k] | tr_v[k]), 0);
    run_trace(0, 3, -1, -1, -1, 4);
    for (int k = 1; k < 4; k++) chk("illegal_w_busy", AW'(tr_busy[k] | tr_c1[k]), 0);
    run_trace(4, 3, -1, -1, -1, 24);
    chk("legal_after_illegal_done", AW'(tr_done[GAP ? 21 : 17]), 1);

    // reset during cycle 6 of a frame
    run_trace(4, 3, -1, -1, 6, 12);
    chk("rst_busy7", AW'(tr_busy[7]), 0);
    chk("rst_addr7", tr_addr[7], 0);
    for (int k = 7; k < 12; k++) chk("rst_no_done", AW'(tr_done[k]), 0);
    run_trace(4, 3, -1, -1, -1, 24);
    chk("restart_addr1", tr_addr[1], 0);
    chk("restart_v1", AW'(tr_v[1]), 1);

    // width 1
    run_trace(1, 3, -1, -1, -1, 12);
    chk("w1_c1mc", AW'({tr_c1[1], tr_mc[1]}), 3);
`ifdef RASTER_ROW_GAP_EN
    chk("w1_addr5", tr_addr[5], 2);
    chk("w1_flush7", AW'({tr_v[7], tr_c1[7], tr_mc[7]}), 3);
    chk("w1_done9", AW'(tr_done[9]), 1);
`else
    chk("w1_addr3", tr_addr[3], 2);
    chk("w1_flush4", AW'({tr_v[4], tr_c1[4], tr_mc[4]}), 3);
    chk("w1_done5", AW'(tr_done[5]), 1);
`endif

    // random traffic, checked by the model only
    for (int k = 0; k < 3000; k++) begin
      rst      = ($urandom_range(0, 399) == 0);
      i_start  = ($urandom_range(0, 9) == 0);
      i_width  = XB'($urandom_range(0, 6));
      i_height = YB'($urandom_range(1, 6));
      i_stall  = ($urandom_range(0, 3) == 0);
      @(posedge clk); #1;
    end
    rst = 0; i_start = 0; i_stall = 0;
    repeat (60) @(posedge clk);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
